// File: rtl/mining_pkg.sv
// Shared types, sizes and byte-order helpers for the nonce-sweep controller.
package mining_pkg;
    localparam int HDR_BYTES       = 80;
    localparam int HDR_W           = HDR_BYTES * 8;
    localparam int NONCE_W         = 32;
    localparam int NONCE_FIELD_LSB = 0;
    localparam int CNT_W           = $clog2(HDR_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } state_t;

    function automatic logic [255:0] bswap256(input logic [255:0] d);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[8*(31-i) +: 8];
        end
        return r;
    endfunction

    // Self-inverse: maps a nonce to its header field and back.
    function automatic logic [NONCE_W-1:0] nonce_le(input logic [NONCE_W-1:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction
endpackage

// File: rtl/mining_ctrl_target.sv
// Combinational difficulty test: hit when the leading zero_bits bits of the byte-reversed digest are zero.
module target_check
    import mining_pkg::*;
(
    input  logic [255:0] digest_i,
    input  logic [7:0]   zero_bits_i,
    output logic         hit_o
);
    logic [255:0] value;
    logic [255:0] mask;

    assign value = bswap256(digest_i);
    assign mask  = ~({256{1'b1}} >> zero_bits_i);
    assign hit_o = ((value & mask) == '0);
endmodule

// File: rtl/mining_ctrl.sv
// Loads an 80-byte header, sweeps the nonce through the sha256 core and reports the first hit.
// One job per nonce (>= 3 cycles + hash latency); header bytes accepted only while idle.
module mining_ctrl
    import mining_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [7:0]         load_data,
    output logic               load_ready,
    input  logic [7:0]         zero_bits,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    output logic               sha_start,
    output logic [HDR_W-1:0]   sha_block,
    input  logic [255:0]       sha_hash,
    input  logic               sha_done,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [255:0]       result_hash,
    output logic [31:0]        attempts
);
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [HDR_W-1:0]     header_q, header_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [31:0]          attempts_q, attempts_d;
    logic [255:0]         hash_q, hash_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 accept, loaded, hit, nonce_max;

    target_check u_target (
        .digest_i    (hash_q),
        .zero_bits_i (zero_bits),
        .hit_o       (hit)
    );

    // Gated by rst_n so every output reads 0 while reset is held.
    assign load_ready = rst_n && (state_q == ST_IDLE);
    assign accept     = load_valid && load_ready;
    assign loaded     = (byte_cnt_q == CNT_W'(HDR_BYTES));
    assign nonce_max  = (nonce_q == '1);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        header_d    = header_q;
        nonce_d     = nonce_q;
        attempts_d  = attempts_q;
        hash_d      = hash_q;
        stop_pend_d = stop_pend_q;

        if (accept) begin
            header_d   = {header_q[HDR_W-9:0], load_data};
            byte_cnt_d = loaded ? CNT_W'(1) : byte_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (cmd_start && !cmd_stop && loaded) begin
                    state_d    = ST_ISSUE;
                    attempts_d = '0;
                    nonce_d    = nonce_le(header_q[NONCE_FIELD_LSB +: NONCE_W]);
                end
            end
            ST_ISSUE: state_d = cmd_stop ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                stop_pend_d = stop_pend_q | cmd_stop;
                if (sha_done) begin
                    hash_d     = sha_hash;
                    attempts_d = (attempts_q == '1) ? attempts_q : attempts_q + 32'd1;
                    if (stop_pend_q || cmd_stop) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    state_d = ST_FOUND;
                end else if (nonce_max) begin
                    state_d = ST_EXHAUSTED;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_FOUND: begin
                if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (cmd_start) begin
                    if (nonce_max) begin
                        state_d = ST_EXHAUSTED;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_EXHAUSTED: if (cmd_stop || cmd_start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            header_q    <= '0;
            nonce_q     <= '0;
            attempts_q  <= '0;
            hash_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            header_q    <= header_d;
            nonce_q     <= nonce_d;
            attempts_q  <= attempts_d;
            hash_q      <= hash_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign sha_start    = (state_q == ST_ISSUE) && !cmd_stop;
    assign sha_block    = {header_q[HDR_W-1:32], nonce_le(nonce_q)};
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign found        = (state_q == ST_FOUND);
    assign exhausted    = (state_q == ST_EXHAUSTED);
    assign result_nonce = nonce_q;
    assign result_hash  = hash_q;
    assign attempts     = attempts_q;
endmodule

// File: tb/tb_mining_ctrl.sv
// Bench for mining_ctrl: acts as the sha256 core and checks sweeps against a nonce-by-nonce model.
`timescale 1ns/1ps
module tb_mining_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [7:0]   load_data = '0;
    logic         load_ready;
    logic [7:0]   zero_bits = '0;
    logic         cmd_start = 1'b0;
    logic         cmd_stop = 1'b0;
    logic         sha_start;
    logic [639:0] sha_block;
    logic [255:0] sha_hash;
    logic         sha_done;
    logic         busy, found, exhausted;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [31:0]  attempts;

    int total = 0;
    int bad = 0;
    int starts = 0;
    int dones = 0;
    int sha_lat = 0;
    bit use_win = 1'b0;
    logic [31:0]  win_nonce = '0;
    logic [255:0] win_hash = '0;
    logic [31:0]  mix_seed = 32'h1234_5678;
    logic [639:0] last_blk = '0;

    localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GEN_HASH =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    mining_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .zero_bits(zero_bits), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .sha_start(sha_start), .sha_block(sha_block),
        .sha_hash(sha_hash), .sha_done(sha_done), .busy(busy), .found(found),
        .exhausted(exhausted), .result_nonce(result_nonce), .result_hash(result_hash),
        .attempts(attempts)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] le32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Stand-in digest: deterministic per nonce so the model can recompute it.
    function automatic logic [255:0] hash_of(input logic [31:0] n);
        logic [255:0] h;
        logic [31:0]  x;
        if (use_win && n == win_nonce) return win_hash;
        h = '0;
        x = n ^ mix_seed;
        for (int k = 0; k < 8; k++) begin
            x = x * 32'h9E3779B1 + 32'h7F4A7C15;
            x = x ^ (x >> 15);
            h[32*k +: 32] = x;
        end
        if (use_win) h[7:0] = 8'hFF;
        return h;
    endfunction

    function automatic int lead_zeros(input logic [255:0] h);
        logic [255:0] v;
        int z;
        v = '0;
        for (int i = 0; i < 32; i++) v[255-8*i -: 8] = h[8*i +: 8];
        z = 0;
        for (int b = 255; b >= 0; b--) begin
            if (v[b]) break;
            z++;
        end
        return z;
    endfunction

    task automatic model_sweep(input logic [31:0] s, input int zb, output bit m_found,
                               output logic [31:0] m_nonce, output logic [31:0] m_att,
                               output logic [255:0] m_hash);
        logic [31:0] n;
        n = s; m_att = 0; m_found = 1'b0; m_nonce = s; m_hash = '0;
        for (int i = 0; i < 4096; i++) begin
            m_att++;
            m_nonce = n;
            m_hash = hash_of(n);
            if (lead_zeros(m_hash) >= zb) begin m_found = 1'b1; break; end
            if (n == 32'hFFFFFFFF) break;
            n++;
        end
    endtask

    // sha256 responder: captures the block at sha_start, answers after a latency.
    initial begin : responder
        logic [639:0] blk;
        int lat;
        bit aborted;
        sha_done = 1'b0;
        sha_hash = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && sha_start === 1'b1) begin
                blk = sha_block;
                last_blk = blk;
                starts++;
                lat = (sha_lat > 0) ? sha_lat : int'($urandom_range(1, 5));
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
                    total++;
                    if (sha_block !== blk) begin
                        bad++;
                        $display("FAIL block_stable: got nonce field %h required %h", sha_block[31:0], blk[31:0]);
                    end
                end
                if (!aborted) begin
                    sha_hash = hash_of(le32(blk[31:0]));
                    sha_done = 1'b1;
                    @(negedge clk);
                    sha_done = 1'b0;
                    dones++;
                end
            end
        end
    end

    task automatic pulse(input bit st, input bit sp);
        cmd_start = st; cmd_stop = sp;
        @(posedge clk); #1;
        cmd_start = 1'b0; cmd_stop = 1'b0;
    endtask

    task automatic send_bytes(input logic [639:0] hdr, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            load_valid = 1'b1;
            load_data = hdr[639-8*i -: 8];
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int c;
        c = 0;
        while (!(found === 1'b1 || exhausted === 1'b1) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout: no found/exhausted after %0d cycles", name, budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, found, exhausted, sha_start, load_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b required 00000", {busy, found, exhausted, sha_start, load_ready});
        end
        total++;
        if ({result_nonce, attempts, result_hash} !== '0 || sha_block !== '0) begin
            bad++; $display("FAIL reset_data: got nonce=%h att=%h required 0", result_nonce, attempts);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({load_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL reset_release: got ready/busy %b required 10", {load_ready, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic run_genesis(input logic [31:0] field, input int exp_att, input string name);
        logic [639:0] hdr;
        int s0;
        hdr = GEN_HDR; hdr[31:0] = field;
        zero_bits = 8'd32; use_win = 1'b1; win_nonce = 32'h7C2BAC1D; win_hash = GEN_HASH; sha_lat = 0;
        s0 = starts;
        send_bytes(hdr, 0, 80);
        pulse(1'b1, 1'b0);
        wait_end(2000, name);
        total++;
        if ({found, exhausted, busy} !== 3'b100) begin
            bad++; $display("FAIL %s_flags: got %b required 100", name, {found, exhausted, busy});
        end
        total++;
        if (result_nonce !== 32'h7C2BAC1D) begin
            bad++; $display("FAIL %s_nonce: got %h required 7c2bac1d", name, result_nonce);
        end
        total++;
        if (result_hash !== GEN_HASH) begin
            bad++; $display("FAIL %s_hash: got %h required %h", name, result_hash, GEN_HASH);
        end
        total++;
        if (attempts !== 32'(exp_att) || starts - s0 != exp_att) begin
            bad++; $display("FAIL %s_attempts: got att=%0d starts=%0d required %0d", name, attempts, starts - s0, exp_att);
        end
        total++;
        if (last_blk !== GEN_HDR) begin
            bad++; $display("FAIL %s_block: got nonce field %h required 1dac2b7c", name, last_blk[31:0]);
        end
        pulse(1'b0, 1'b1);
        total++;
        if ({found, load_ready} !== 2'b01) begin
            bad++; $display("FAIL %s_stop: got found/ready %b required 01", name, {found, load_ready});
        end
    endtask

    task automatic test_genesis();       run_genesis(32'h1dac2b7c, 1, "genesis");       endtask
    task automatic test_genesis_sweep(); run_genesis(32'h1bac2b7c, 3, "genesis_sweep"); endtask

    task automatic test_exhaust();
        logic [639:0] hdr;
        int s0;
        hdr = GEN_HDR; hdr[31:0] = 32'hfeffffff;
        zero_bits = 8'd255; use_win = 1'b1; win_nonce = 32'h0; sha_lat = 0;
        s0 = starts;
        send_bytes(hdr, 0, 80);
        pulse(1'b1, 1'b0);
        wait_end(2000, "exhaust");
        total++;
        if ({found, exhausted} !== 2'b01 || result_nonce !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL exhaust_state: got f/e=%b nonce=%h required 01 ffffffff", {found, exhausted}, result_nonce);
        end
        total++;
        if (attempts !== 32'd2 || starts - s0 != 2) begin
            bad++; $display("FAIL exhaust_attempts: got att=%0d starts=%0d required 2", attempts, starts - s0);
        end
        total++;
        if (result_hash !== hash_of(32'hFFFFFFFF)) begin
            bad++; $display("FAIL exhaust_hash: got %h required %h", result_hash, hash_of(32'hFFFFFFFF));
        end
        pulse(1'b1, 1'b0);
        total++;
        if ({exhausted, busy, load_ready} !== 3'b001) begin
            bad++; $display("FAIL exhaust_restart: got e/b/r %b required 001", {exhausted, busy, load_ready});
        end
    endtask

    task automatic test_stop_in_wait();
        int s0, d0, busy_low, c;
        zero_bits = 8'd0; sha_lat = 8;
        s0 = starts; d0 = dones; busy_low = 0; c = 0;
        pulse(1'b1, 1'b0);
        @(posedge clk); #1;
        pulse(1'b0, 1'b1);
        while (c < 40) begin
            @(negedge clk); #1;
            if (dones != d0) break;
            if (busy !== 1'b1) busy_low++;
            c++;
        end
        total++;
        if (dones == d0 || busy_low != 0) begin
            bad++; $display("FAIL stop_wait_busy: got done=%0d busy_low_cycles=%0d required 1 0", dones - d0, busy_low);
        end
        total++;
        if ({busy, found, load_ready} !== 3'b001 || attempts !== 32'd1) begin
            bad++; $display("FAIL stop_wait_idle: got b/f/r=%b att=%0d required 001 1", {busy, found, load_ready}, attempts);
        end
        repeat (10) @(negedge clk);
        total++;
        if (starts - s0 != 1 || found !== 1'b0) begin
            bad++; $display("FAIL stop_wait_quiet: got starts=%0d found=%b required 1 0", starts - s0, found);
        end
        sha_lat = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_partial_load();
        logic [639:0] hdr;
        logic [31:0] s;
        int s0;
        rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
        for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
        s = $urandom; hdr[31:0] = le32(s);
        zero_bits = 8'd0; use_win = 1'b0;
        s0 = starts;
        send_bytes(hdr, 0, 79);
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        total++;
        if (starts != s0 || busy !== 1'b0) begin
            bad++; $display("FAIL partial_79: got starts=%0d busy=%b required 0 0", starts - s0, busy);
        end
        @(posedge clk); #1;
        send_bytes(hdr, 79, 1);
        pulse(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (starts != s0 || {busy, load_ready} !== 2'b01) begin
            bad++; $display("FAIL start_and_stop: got starts=%0d b/r=%b required 0 01", starts - s0, {busy, load_ready});
        end
        @(posedge clk); #1;
        pulse(1'b1, 1'b0);
        wait_end(2000, "partial");
        total++;
        if (found !== 1'b1 || result_nonce !== s || attempts !== 32'd1 || starts - s0 != 1 || last_blk !== hdr) begin
            bad++; $display("FAIL partial_run: got f=%b nonce=%h att=%0d required 1 %h 1", found, result_nonce, attempts, s);
        end
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [639:0] hdr;
        int s0;
        for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
        hdr[31:0] = le32(32'h12345678);
        zero_bits = 8'd255; use_win = 1'b1; win_nonce = 32'h0; sha_lat = 10;
        send_bytes(hdr, 0, 80);
        pulse(1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, found, exhausted, sha_start, load_ready} !== 5'b0 || sha_block !== '0) begin
            bad++; $display("FAIL reset_mid_flags: got %b required 00000", {busy, found, exhausted, sha_start, load_ready});
        end
        total++;
        if ({result_nonce, attempts, result_hash} !== '0) begin
            bad++; $display("FAIL reset_mid_data: got nonce=%h att=%h required 0", result_nonce, attempts);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        sha_lat = 0;
        s0 = starts;
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        total++;
        if (starts != s0 || {busy, load_ready} !== 2'b01) begin
            bad++; $display("FAIL reset_mid_unloaded: got starts=%0d b/r=%b required 0 01", starts - s0, {busy, load_ready});
        end
        @(posedge clk); #1;
        zero_bits = 8'd0;
        send_bytes(hdr, 0, 80);
        pulse(1'b1, 1'b0);
        wait_end(2000, "reset_mid");
        total++;
        if (found !== 1'b1 || result_nonce !== 32'h12345678 || attempts !== 32'd1) begin
            bad++; $display("FAIL reset_mid_reload: got f=%b nonce=%h att=%0d required 1 12345678 1", found, result_nonce, attempts);
        end
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [639:0] hdr;
        logic [31:0] s, m_nonce, m_att;
        logic [255:0] m_hash;
        bit m_found;
        int s0;
        for (int it = 0; it < 4; it++) begin
            mix_seed = $urandom; use_win = 1'b0; sha_lat = 0;
            s = (it % 2 == 1) ? 32'hFFFFFFFF - $urandom_range(0, 5) : $urandom;
            zero_bits = 8'($urandom_range(0, 5));
            for (int w = 0; w < 20; w++) hdr[32*w +: 32] = $urandom;
            hdr[31:0] = le32(s);
            model_sweep(s, int'(zero_bits), m_found, m_nonce, m_att, m_hash);
            s0 = starts;
            send_bytes(hdr, 0, 80);
            pulse(1'b1, 1'b0);
            wait_end(8000, "random");
            total++;
            if (found !== m_found || exhausted !== !m_found || result_nonce !== m_nonce) begin
                bad++; $display("FAIL random%0d_outcome: got f=%b e=%b nonce=%h required f=%b nonce=%h", it, found, exhausted, result_nonce, m_found, m_nonce);
            end
            total++;
            if (attempts !== m_att || starts - s0 != int'(m_att) || result_hash !== m_hash) begin
                bad++; $display("FAIL random%0d_count: got att=%0d starts=%0d hash=%h required %0d %h", it, attempts, starts - s0, result_hash, m_att, m_hash);
            end
            pulse(1'b0, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_genesis();
        test_genesis_sweep();
        test_exhaust();
        test_stop_in_wait();
        test_partial_load();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
